// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority pick used by the 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set bit strictly after last, wrapping; returns last when req is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/onehot_enc_4_to_2.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module onehot_enc_4_to_2
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] oh,
  output logic [IDX_W-1:0] idx
);

  assign idx[1] = oh[3] | oh[2];
  assign idx[0] = oh[3] | oh[1];

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with grant lock and optional hold-timeout preemption.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  // With preemption disabled the counter just saturates at its maximum.
  localparam logic [CNT_W-1:0] HOLD_LIM = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX) : '1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
  logic [IDX_W-1:0] sel;
  logic             owner_req, others_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    sel       = rr_pick(req, last_q);
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d   = N_REQ'(1) << sel;
          last_d  = sel;
          hold_d  = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release wins over a coincident timeout, so no preempt pulse then.
        if (!owner_req) begin
          gnt_d   = '0;
          hold_d  = '0;
          state_d = IDLE;
        end else if ((HOLD_MAX > 0) && (hold_q == HOLD_LIM) && others_req) begin
          gnt_d     = '0;
          hold_d    = '0;
          preempt_d = 1'b1;
          state_d   = IDLE;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  onehot_enc_4_to_2 u_enc (
    .oh  (gnt_q),
    .idx (gnt_idx)
  );

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench: two arbiters (HOLD_MAX=0 and HOLD_MAX=3) driven by directed vectors.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req0 = '0, req3 = '0;
  logic [3:0] gnt0, gnt3;
  logic [1:0] idx0, idx3;
  logic       vld0, vld3, pre0, pre3;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         c;
    int         dut;
    logic [7:0] e;   // {gnt[3:0], idx[1:0], valid, preempt}
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_arbiter_4 #(.HOLD_MAX(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .preempt(pre0)
  );

  rr_arbiter_4 #(.HOLD_MAX(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3),
    .gnt(gnt3), .gnt_idx(idx3), .gnt_valid(vld3), .preempt(pre3)
  );

  // Monitor: outputs are presented every cycle; compare whatever is due now.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t       x;
      logic [7:0] act;
      x = q.pop_front();
      act = (x.dut == 0) ? {gnt0, idx0, vld0, pre0} : {gnt3, idx3, vld3, pre3};
      checks++;
      if (x.c != cyc || act !== x.e) begin
        errors++;
        $display("FAIL out_dut%0d cyc=%0d: got gnt/idx/v/p=%b_%b_%b_%b expected %b_%b_%b_%b (due cyc %0d)",
                 x.dut, cyc, act[7:4], act[3:2], act[1], act[0],
                 x.e[7:4], x.e[3:2], x.e[1], x.e[0], x.c);
      end
    end
  end

  // Drive one cycle of inputs; e0/e3 are the outputs expected after the next edge.
  task automatic step(input logic rn, input logic [3:0] r0, input logic [3:0] r3,
                      input logic [7:0] e0, input logic [7:0] e3);
    exp_t x;
    rst_n = rn;
    req0  = r0;
    req3  = r3;
    x.c = cyc + 1; x.dut = 0; x.e = e0; q.push_back(x);
    x.c = cyc + 1; x.dut = 1; x.e = e3; q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] Z     = 8'b0000_00_0_0;
  localparam logic [7:0] G0    = 8'b0001_00_1_0;
  localparam logic [7:0] G1    = 8'b0010_01_1_0;
  localparam logic [7:0] G2    = 8'b0100_10_1_0;
  localparam logic [7:0] G3    = 8'b1000_11_1_0;
  localparam logic [7:0] PRE   = 8'b0000_00_0_1;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle with no requests.
    repeat (2) step(0, 4'b0000, 4'b0000, Z, Z);
    repeat (5) step(1, 4'b0000, 4'b0000, Z, Z);

    // HOLD_MAX=0: all request, owner 0 locks; then rotation with idle gaps.
    step(1, 4'b1111, 4'b0000, G0, Z);
    repeat (4) step(1, 4'b1111, 4'b0000, G0, Z);
    step(1, 4'b1110, 4'b0000, Z,  Z);
    step(1, 4'b1110, 4'b0000, G1, Z);
    step(1, 4'b1100, 4'b0000, Z,  Z);
    step(1, 4'b1100, 4'b0000, G2, Z);
    step(1, 4'b1000, 4'b0000, Z,  Z);
    step(1, 4'b1000, 4'b0000, G3, Z);
    step(1, 4'b0001, 4'b0000, Z,  Z);
    // last=3 after wrap: 0 beats 3.
    step(1, 4'b1001, 4'b0000, G0, Z);
    step(1, 4'b0000, 4'b0000, Z,  Z);

    // HOLD_MAX=3, single requester keeps grant well past the limit.
    step(0, 4'b0000, 4'b0000, Z, Z);
    step(1, 4'b0000, 4'b0100, Z, G2);
    repeat (10) step(1, 4'b0000, 4'b0100, Z, G2);

    // HOLD_MAX=3, competing 0 and 1: last=2 so 0 wins, preempted after 3 cycles.
    step(1, 4'b0000, 4'b0011, Z, Z);
    step(1, 4'b0000, 4'b0011, Z, G0);
    step(1, 4'b0000, 4'b0011, Z, G0);
    step(1, 4'b0000, 4'b0011, Z, G0);
    step(1, 4'b0000, 4'b0011, Z, PRE);
    step(1, 4'b0000, 4'b0011, Z, G1);
    step(1, 4'b0000, 4'b0011, Z, G1);
    step(1, 4'b0000, 4'b0011, Z, G1);
    // Owner drops exactly at the timeout: release, no preempt pulse.
    step(1, 4'b0000, 4'b0001, Z, Z);
    step(1, 4'b0000, 4'b0001, Z, G0);
    step(1, 4'b0000, 4'b0000, Z, Z);

    // Reset mid-grant, pointer restarts at 3 so requester 1 is granted again.
    step(1, 4'b0010, 4'b0010, G1, G1);
    step(1, 4'b0010, 4'b0010, G1, G1);
    step(0, 4'b0010, 4'b0010, Z,  Z);
    step(1, 4'b0010, 4'b0010, G1, G1);
    step(1, 4'b0000, 4'b0000, Z,  Z);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
